id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports (name direction width meaning): clk input 1 clock, rising edge; rst_n input 1 reset, synchronous, active-low.
REQ-002 SHALL have: stall input 1 hold contents; flush input 1 insert bubble; id_valid input 1 decode slot holds a real instruction.
REQ-003 SHALL have: id_opcode input 5; id_funct input 2; id_pc input 16; id_imm input 8; id_rs_data input 16; id_rt_data input 16 (register-file read data).
REQ-004 SHALL have: id_rs_sel input 3; id_rt_sel input 3; id_wr_sel input 3; id_wr_en input 1.
REQ-005 SHALL have: exm_wr_en input 1; exm_wr_sel input 3; exm_wr_data input 16 (EX/MEM result); wb_wr_en input 1; wb_wr_sel input 3; wb_wr_data input 16 (write-back port).
REQ-006 SHALL have: ex_valid, ex_wr_en output 1; ex_opcode output 5; ex_funct output 2; ex_pc, ex_rs, ex_rt output 16; ex_imm output 8; ex_wr_sel output 3; fwd_rs_src, fwd_rt_src output 2 (0 latched, 1 EX/MEM, 2 WB).
REQ-007 SHALL use one clock; reset synchronous and active-low.

Function
REQ-008 SHALL be the decode-to-execute pipeline register feeding the ALU; latency exactly 1 cycle ID->EX.
REQ-009 Per rising edge, priority: !rst_n > flush > stall > load.
REQ-010 flush=1: ex_valid<=0, latched wr_en<=0; other fields don't-care but SHALL be zeroed; flush overrides simultaneous stall.
REQ-011 stall=1, flush=0: all fields hold, except latched rs/rt refresh per REQ-015.
REQ-012 load (stall=0, flush=0): capture all id_* fields; ex_valid<=id_valid.
REQ-013 Capture-time bypass: if wb_wr_en and wb_wr_sel==id_rs_sel, latched rs<=wb_wr_data, else id_rs_data; same for rt.
REQ-014 Output forwarding (combinational, EX/MEM priority over WB): ex_rs = exm_wr_data if exm_wr_en && exm_wr_sel==latched rs_sel; else wb_wr_data if wb_wr_en && wb_wr_sel==latched rs_sel; else latched rs; fwd_rs_src reports choice; same for rt.
REQ-015 While stalled, each cycle latched rs<=ex_rs and rt<=ex_rt, so a producer leaving WB during stall is not lost.
REQ-016 Forwarding SHALL apply only when ex_valid=1; when ex_valid=0 fwd_*_src=0 and ex_rs/ex_rt = latched values.
REQ-017 ex_wr_en = latched wr_en AND ex_valid.
REQ-018 No register is hardwired to zero; selector 0 forwards like any other.
REQ-019 All outputs other than ex_rs/ex_rt/fwd_* SHALL be direct register outputs.

Reset
REQ-020 When rst_n=0 at a rising edge, all registered state SHALL clear to 0 (ex_valid=0, ex_wr_en=0, all fields 0), overriding stall/flush and aborting any held instruction.
REQ-021 Outputs SHALL remain 0 until first load edge after rst_n returns to 1.

Configuration
REQ-022 Macro ID_EX_FWD_EN: defined -> REQ-013..REQ-016 active.
REQ-023 Undefined -> no capture bypass, no output forwarding, no stall refresh; ex_rs/ex_rt = latched id_rs_data/id_rt_data; fwd_*_src tie to 0; exm_*/wb_* inputs unused.

Verification
REQ-024 rst_n=0 one edge with stall=1, id_valid=1 -> all outputs 0 next cycle.
REQ-025 Load id_opcode=5'b01000, id_rs_data=16'h0003, id_valid=1, no matches -> next cycle ex_opcode=5'b01000, ex_rs=16'h0003, ex_valid=1, fwd_rs_src=0.
REQ-026 Latched rs_sel=2, exm_wr_en=1 sel=2 data=16'hBEEF, wb_wr_en=1 sel=2 data=16'h1234 -> ex_rs=16'hBEEF, fwd_rs_src=1; drop exm_wr_en -> ex_rs=16'h1234, fwd_rs_src=2.
REQ-027 stall=1 two cycles; cycle 1 wb writes r3=16'h00AA matching rt_sel=3; cycle 2 no matches -> ex_rt stays 16'h00AA.
REQ-028 stall=1 and flush=1 same edge with ex_valid=1, id_wr_en=1 -> ex_valid=0, ex_wr_en=0.
REQ-029 Capture with wb_wr_en=1 sel=5 data=16'h7777, id_rs_sel=5, id_rs_data=16'h0000 -> ex_rs=16'h7777 (FWD_EN defined), 16'h0000 (undefined).

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand forwarding; optional feature macro ID_EX_FWD_EN.
// Latency: 1 cycle ID->EX; forwarding muxes on ex_rs/ex_rt are combinational from the latched selectors.
// Backpressure: stall holds the slot (operands refresh from forwarding), flush inserts a bubble and wins over stall.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [4:0]  id_opcode,
    input  logic [1:0]  id_funct,
    input  logic [15:0] id_pc,
    input  logic [7:0]  id_imm,
    input  logic [15:0] id_rs_data,
    input  logic [15:0] id_rt_data,
    input  logic [2:0]  id_rs_sel,
    input  logic [2:0]  id_rt_sel,
    input  logic [2:0]  id_wr_sel,
    input  logic        id_wr_en,
    input  logic        exm_wr_en,
    input  logic [2:0]  exm_wr_sel,
    input  logic [15:0] exm_wr_data,
    input  logic        wb_wr_en,
    input  logic [2:0]  wb_wr_sel,
    input  logic [15:0] wb_wr_data,
    output logic        ex_valid,
    output logic        ex_wr_en,
    output logic [4:0]  ex_opcode,
    output logic [1:0]  ex_funct,
    output logic [15:0] ex_pc,
    output logic [15:0] ex_rs,
    output logic [15:0] ex_rt,
    output logic [7:0]  ex_imm,
    output logic [2:0]  ex_wr_sel,
    output logic [1:0]  fwd_rs_src,
    output logic [1:0]  fwd_rt_src
);

    logic        wr_en_q;
    logic [2:0]  rs_sel_q;
    logic [2:0]  rt_sel_q;
    logic [15:0] rs_q;
    logic [15:0] rt_q;
    logic [15:0] rs_cap;
    logic [15:0] rt_cap;

`ifdef ID_EX_FWD_EN
    // EX/MEM is the younger producer, so it is checked before WB.
    always_comb begin
        fwd_rs_src = 2'd0;
        fwd_rt_src = 2'd0;
        ex_rs      = rs_q;
        ex_rt      = rt_q;
        if (ex_valid) begin
            if (exm_wr_en && exm_wr_sel == rs_sel_q) begin
                fwd_rs_src = 2'd1;
                ex_rs      = exm_wr_data;
            end else if (wb_wr_en && wb_wr_sel == rs_sel_q) begin
                fwd_rs_src = 2'd2;
                ex_rs      = wb_wr_data;
            end
            if (exm_wr_en && exm_wr_sel == rt_sel_q) begin
                fwd_rt_src = 2'd1;
                ex_rt      = exm_wr_data;
            end else if (wb_wr_en && wb_wr_sel == rt_sel_q) begin
                fwd_rt_src = 2'd2;
                ex_rt      = wb_wr_data;
            end
        end
    end

    // The register file write in the same cycle is not yet visible on its read port.
    assign rs_cap = (wb_wr_en && wb_wr_sel == id_rs_sel) ? wb_wr_data : id_rs_data;
    assign rt_cap = (wb_wr_en && wb_wr_sel == id_rt_sel) ? wb_wr_data : id_rt_data;
`else
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign fwd_rs_src = 2'd0;
    assign fwd_rt_src = 2'd0;
    assign rs_cap     = id_rs_data;
    assign rt_cap     = id_rt_data;

    logic unused_fwd;
    assign unused_fwd = ^{exm_wr_en, exm_wr_sel, exm_wr_data, wb_wr_en, wb_wr_sel,
                          wb_wr_data, rs_sel_q, rt_sel_q};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            ex_valid  <= 1'b0;
            wr_en_q   <= 1'b0;
            ex_opcode <= '0;
            ex_funct  <= '0;
            ex_pc     <= '0;
            ex_imm    <= '0;
            ex_wr_sel <= '0;
            rs_sel_q  <= '0;
            rt_sel_q  <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
        end else if (stall) begin
`ifdef ID_EX_FWD_EN
            // Keep whatever is being forwarded now; the producer may retire before the stall ends.
            rs_q <= ex_rs;
            rt_q <= ex_rt;
`endif
        end else begin
            ex_valid  <= id_valid;
            wr_en_q   <= id_wr_en;
            ex_opcode <= id_opcode;
            ex_funct  <= id_funct;
            ex_pc     <= id_pc;
            ex_imm    <= id_imm;
            ex_wr_sel <= id_wr_sel;
            rs_sel_q  <= id_rs_sel;
            rt_sel_q  <= id_rt_sel;
            rs_q      <= rs_cap;
            rt_q      <= rt_cap;
        end
    end

    assign ex_wr_en = wr_en_q & ex_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboarded random bench for id_ex_stage; follows ID_EX_FWD_EN like the design does.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid, id_wr_en, exm_wr_en, wb_wr_en;
    logic [4:0]  id_opcode;
    logic [1:0]  id_funct;
    logic [15:0] id_pc, id_rs_data, id_rt_data, exm_wr_data, wb_wr_data;
    logic [7:0]  id_imm;
    logic [2:0]  id_rs_sel, id_rt_sel, id_wr_sel, exm_wr_sel, wb_wr_sel;
    logic        ex_valid, ex_wr_en;
    logic [4:0]  ex_opcode;
    logic [1:0]  ex_funct, fwd_rs_src, fwd_rt_src;
    logic [15:0] ex_pc, ex_rs, ex_rt;
    logic [7:0]  ex_imm;
    logic [2:0]  ex_wr_sel;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_funct(id_funct), .id_pc(id_pc), .id_imm(id_imm),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_rs_sel(id_rs_sel),
        .id_rt_sel(id_rt_sel), .id_wr_sel(id_wr_sel), .id_wr_en(id_wr_en),
        .exm_wr_en(exm_wr_en), .exm_wr_sel(exm_wr_sel), .exm_wr_data(exm_wr_data),
        .wb_wr_en(wb_wr_en), .wb_wr_sel(wb_wr_sel), .wb_wr_data(wb_wr_data),
        .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_imm(ex_imm), .ex_wr_sel(ex_wr_sel),
        .fwd_rs_src(fwd_rs_src), .fwd_rt_src(fwd_rt_src)
    );

    typedef struct {
        logic        rst_n, stall, flush, valid, wr_en, exm_en, wb_en;
        logic [4:0]  opcode;
        logic [1:0]  funct;
        logic [15:0] pc, rs_data, rt_data, exm_data, wb_data;
        logic [7:0]  imm;
        logic [2:0]  rs_sel, rt_sel, wr_sel, exm_sel, wb_sel;
    } stim_t;

    typedef struct {
        logic        valid, wr_en;
        logic [4:0]  opcode;
        logic [1:0]  funct, rs_src, rt_src;
        logic [15:0] pc, rs, rt;
        logic [7:0]  imm;
        logic [2:0]  wr_sel;
    } exp_t;

    // Reference: the instruction sitting in EX, as a plain record.
    typedef struct {
        logic        valid, wr_en;
        logic [4:0]  opcode;
        logic [1:0]  funct;
        logic [15:0] pc, rs, rt;
        logic [7:0]  imm;
        logic [2:0]  rs_sel, rt_sel, wr_sel;
    } slot_t;

    slot_t slot;
    exp_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst_n    = ($urandom_range(0, 31) != 0);
        s.flush    = ($urandom_range(0, 7) == 0);
        s.stall    = ($urandom_range(0, 3) == 0);
        s.valid    = ($urandom_range(0, 3) != 0);
        s.wr_en    = 1'($urandom);
        s.exm_en   = 1'($urandom);
        s.wb_en    = 1'($urandom);
        s.opcode   = 5'($urandom);
        s.funct    = 2'($urandom);
        s.pc       = 16'($urandom);
        s.imm      = 8'($urandom);
        s.rs_data  = 16'($urandom);
        s.rt_data  = 16'($urandom);
        s.exm_data = 16'($urandom);
        s.wb_data  = 16'($urandom);
        s.rs_sel   = 3'($urandom_range(0, 3));
        s.rt_sel   = 3'($urandom_range(0, 3));
        s.wr_sel   = 3'($urandom);
        s.exm_sel  = 3'($urandom_range(0, 3));
        s.wb_sel   = 3'($urandom_range(0, 3));
        return s;
    endfunction

    // Value an ALU operand with register number 'sel' should see right now.
    function automatic void operand(input stim_t s, input logic [2:0] sel, input logic [15:0] held,
                                    output logic [15:0] val, output logic [1:0] src);
        val = held;
        src = 2'd0;
`ifdef ID_EX_FWD_EN
        if (slot.valid) begin
            if (s.exm_en && s.exm_sel == sel) begin
                val = s.exm_data; src = 2'd1;
            end else if (s.wb_en && s.wb_sel == sel) begin
                val = s.wb_data; src = 2'd2;
            end
        end
`endif
    endfunction

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        e.valid  = slot.valid;
        e.wr_en  = slot.valid && slot.wr_en;
        e.opcode = slot.opcode;
        e.funct  = slot.funct;
        e.pc     = slot.pc;
        e.imm    = slot.imm;
        e.wr_sel = slot.wr_sel;
        operand(s, slot.rs_sel, slot.rs, e.rs, e.rs_src);
        operand(s, slot.rt_sel, slot.rt, e.rt, e.rt_src);
        return e;
    endfunction

    function automatic logic [15:0] regfile_read(input stim_t s, input logic [2:0] sel,
                                                 input logic [15:0] rd);
`ifdef ID_EX_FWD_EN
        if (s.wb_en && s.wb_sel == sel) return s.wb_data;
`endif
        return rd;
    endfunction

    function automatic void advance(input stim_t s, input exp_t e);
        if (!s.rst_n || s.flush) begin
            slot = '{default: '0};
        end else if (s.stall) begin
`ifdef ID_EX_FWD_EN
            slot.rs = e.rs;
            slot.rt = e.rt;
`endif
        end else begin
            slot.valid  = s.valid;
            slot.wr_en  = s.wr_en;
            slot.opcode = s.opcode;
            slot.funct  = s.funct;
            slot.pc     = s.pc;
            slot.imm    = s.imm;
            slot.rs_sel = s.rs_sel;
            slot.rt_sel = s.rt_sel;
            slot.wr_sel = s.wr_sel;
            slot.rs     = regfile_read(s, s.rs_sel, s.rs_data);
            slot.rt     = regfile_read(s, s.rt_sel, s.rt_data);
        end
    endfunction

    // Drives one cycle's inputs just after a rising edge and queues the outputs expected before the next one.
    task automatic step(input stim_t s, input bit chk);
        exp_t e;
        rst_n = s.rst_n; stall = s.stall; flush = s.flush; id_valid = s.valid;
        id_wr_en = s.wr_en; id_opcode = s.opcode; id_funct = s.funct; id_pc = s.pc;
        id_imm = s.imm; id_rs_data = s.rs_data; id_rt_data = s.rt_data;
        id_rs_sel = s.rs_sel; id_rt_sel = s.rt_sel; id_wr_sel = s.wr_sel;
        exm_wr_en = s.exm_en; exm_wr_sel = s.exm_sel; exm_wr_data = s.exm_data;
        wb_wr_en = s.wb_en; wb_wr_sel = s.wb_sel; wb_wr_data = s.wb_data;
        e = predict(s);
        if (chk) sb_q.push_back(e);
        @(posedge clk);
        advance(s, e);
        #1;
    endtask

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp("ex_valid",   16'(ex_valid),   16'(e.valid));
            cmp("ex_wr_en",   16'(ex_wr_en),   16'(e.wr_en));
            cmp("ex_opcode",  16'(ex_opcode),  16'(e.opcode));
            cmp("ex_funct",   16'(ex_funct),   16'(e.funct));
            cmp("ex_pc",      ex_pc,           e.pc);
            cmp("ex_imm",     16'(ex_imm),     16'(e.imm));
            cmp("ex_wr_sel",  16'(ex_wr_sel),  16'(e.wr_sel));
            cmp("ex_rs",      ex_rs,           e.rs);
            cmp("ex_rt",      ex_rt,           e.rt);
            cmp("fwd_rs_src", 16'(fwd_rs_src), 16'(e.rs_src));
            cmp("fwd_rt_src", 16'(fwd_rt_src), 16'(e.rt_src));
        end
    end

    initial begin
        stim_t s;
        slot = '{default: '0};

        // Unknown power-up state: drive reset but do not check yet.
        s = idle(); s.rst_n = 1'b0;
        step(s, 1'b0);

        // Reset wins over stall with a valid instruction offered.
        s = idle(); s.rst_n = 1'b0; s.stall = 1'b1; s.valid = 1'b1; s.opcode = 5'h1f;
        step(s, 1'b1);

        // Plain load, nothing to forward.
        s = idle(); s.valid = 1'b1; s.opcode = 5'b01000; s.rs_data = 16'h0003; s.rs_sel = 3'd2;
        s.rt_sel = 3'd6; s.rt_data = 16'h0042;
        step(s, 1'b1);

        // EX/MEM and WB both target r2: EX/MEM wins, then WB alone.
        s = idle(); s.stall = 1'b1; s.exm_en = 1'b1; s.exm_sel = 3'd2; s.exm_data = 16'hBEEF;
        s.wb_en = 1'b1; s.wb_sel = 3'd2; s.wb_data = 16'h1234;
        step(s, 1'b1);
        s.exm_en = 1'b0;
        step(s, 1'b1);
        s = idle(); s.stall = 1'b1;
        step(s, 1'b1);

        // WB writes r3 during the first stall cycle; it must persist into the second.
        s = idle(); s.valid = 1'b1; s.rt_sel = 3'd3; s.rt_data = 16'h0011; s.rs_sel = 3'd4;
        step(s, 1'b1);
        s = idle(); s.stall = 1'b1; s.wb_en = 1'b1; s.wb_sel = 3'd3; s.wb_data = 16'h00AA;
        step(s, 1'b1);
        s = idle(); s.stall = 1'b1;
        step(s, 1'b1);
        step(s, 1'b1);

        // Flush beats stall for a valid writer.
        s = idle(); s.valid = 1'b1; s.wr_en = 1'b1; s.wr_sel = 3'd7;
        step(s, 1'b1);
        s = idle(); s.stall = 1'b1; s.flush = 1'b1;
        step(s, 1'b1);

        // Capture-time bypass from the write-back port, then selector 0 forwarding.
        s = idle(); s.valid = 1'b1; s.rs_sel = 3'd5; s.rs_data = 16'h0000;
        s.wb_en = 1'b1; s.wb_sel = 3'd5; s.wb_data = 16'h7777;
        step(s, 1'b1);
        s = idle(); s.valid = 1'b1; s.rs_sel = 3'd0; s.rs_data = 16'h0101;
        step(s, 1'b1);
        s = idle(); s.stall = 1'b1; s.exm_en = 1'b1; s.exm_sel = 3'd0; s.exm_data = 16'h5A5A;
        step(s, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step(rand_stim(), 1'b1);
        end
        step(idle(), 1'b0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
